thermo_ramp: RTL and testbench
==============================

THERMO_RAMP -- requirements
Module: thermo_ramp

Interface
REQ-001 The block SHALL have parameter N_LEDS, default 16, meaning the number of thermometer outputs (legal range 2..64).
REQ-002 The block SHALL have parameter STEP_CYCLES, default 4, meaning the clock cycles per one-level step (legal range 1..65535).
REQ-003 The block SHALL use derived localparam LVL_W = $clog2(N_LEDS+1), meaning the width of all level values.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-006 start  input  1  SHALL be a request strobe, sampled every rising edge.
REQ-007 target  input  LVL_W  SHALL be the requested level, sampled only when start=1.
REQ-008 leds  output  N_LEDS  SHALL be the thermometer code of the current level.
REQ-009 level  output  LVL_W  SHALL be the current lit count.
REQ-010 busy  output  1  SHALL indicate that a ramp is in progress.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-012 leds[i] SHALL be 1 iff i < level, for all i, in every cycle, with no skew relative to level.
REQ-013 The FSM SHALL have states IDLE, UP and DOWN; busy=1 exactly in UP or DOWN.
REQ-014 On start=1, tgt SHALL latch min(target, N_LEDS); larger target values are clamped to N_LEDS.
REQ-015 On start=1, next state SHALL be UP if tgt>level, DOWN if tgt<level, and IDLE if tgt==level, with done=1 at that same edge.
REQ-016 The prescaler SHALL clear to 0 on every start, then increment each UP/DOWN cycle and wrap at STEP_CYCLES-1.
REQ-017 The prescaler wrap edge SHALL be a step: level+1 in UP, level-1 in DOWN; steps occur at edges k+STEP_CYCLES, k+2*STEP_CYCLES, ..., where k is the start-sampling edge.
REQ-018 At the edge where level becomes tgt, the FSM SHALL enter IDLE, busy SHALL go 0 and done SHALL go 1, all at that same edge.
REQ-019 done SHALL stay high exactly one cycle, then return to 0.
REQ-020 start while busy SHALL retarget: re-latch tgt, re-evaluate direction against the current level, and restart the prescaler.
REQ-021 If start coincides with a step edge, start SHALL win: the step is suppressed and direction is evaluated against the pre-step level.
REQ-022 level SHALL never exceed N_LEDS and never underflow below 0.
REQ-023 In IDLE without start, all outputs SHALL hold.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL set level=0, leds=0, busy=0, done=0, tgt=0, prescaler=0 and state=IDLE.
REQ-025 Reset during a ramp SHALL abort it with no done pulse; start is ignored while rst_n=0.

Configuration
REQ-026 With macro THERMO_RAMP_AUTO_RETURN_EN defined, reaching tgt>0 in UP SHALL switch to DOWN with tgt=0, with busy staying 1, no done and the prescaler cleared; done SHALL fire only when level reaches 0.
REQ-027 Without THERMO_RAMP_AUTO_RETURN_EN, the ramp SHALL stop at tgt per REQ-018, and no return logic SHALL be synthesised.

Verification (N_LEDS=8, STEP_CYCLES=4, start sampled at edge 0)
REQ-028 Scenario: from level 0, target=5 -> level 1..5 at edges 4,8,12,16,20; at edge 20 leds=8'h1F, busy 0, done 1 for one cycle.
REQ-029 Scenario: from level 0, target=12 -> clamped; leds=8'hFF at edge 32; level=8; done at edge 32.
REQ-030 Scenario: from level 5, target=2 -> level 4,3,2 at edges 4,8,12; leds=8'h03; then target=2 again -> done at next edge, busy stays 0.
REQ-031 Scenario: ramp 0->6, retarget with target=1 at level 3 coinciding with a step edge -> no step at that edge; level 2 at +4 edges, level 1 at +8 edges, then done.
REQ-032 Scenario: rst_n=0 for one edge at level 3 during UP -> level 0, leds 0, busy 0, done never asserted.
REQ-033 Scenario: with THERMO_RAMP_AUTO_RETURN_EN, target=3 -> level 3 at edge 12, busy stays 1, level 0 at edge 24; done only at edge 24.

Source files
------------

// File: rtl/thermo_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : thermo_ramp
//  Purpose  : Thermometer-code LED ramp. On a start strobe the lit count
//             (level) walks one step every STEP_CYCLES clocks towards the
//             requested target, then pulses done for one cycle.
//  Ports    : clk    - single clock, rising edge
//             rst_n  - synchronous active-low reset
//             start  - request strobe, sampled every edge
//             target - requested level (clamped to N_LEDS), used when start=1
//             leds   - thermometer code: leds[i] = (i < level)
//             level  - current lit count
//             busy   - ramp in progress
//             done   - one-cycle completion pulse
//  Options  : THERMO_RAMP_AUTO_RETURN_EN - after an upward ramp reaches a
//             non-zero target, ramp straight back down to 0 before done.
//  Revision : 1.0 - initial release
// ============================================================================
module thermo_ramp #(
    parameter  int N_LEDS      = 16,
    parameter  int STEP_CYCLES = 4,
    localparam int LVL_W       = $clog2(N_LEDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LVL_W-1:0] target,
    output logic [N_LEDS-1:0] leds,
    output logic [LVL_W-1:0] level,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [LVL_W-1:0] c_max_lvl   = LVL_W'(N_LEDS);
    localparam logic [PRE_W-1:0] c_presc_max = PRE_W'(STEP_CYCLES - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_up   = 2'd1;
    localparam logic [1:0] c_st_down = 2'd2;

    logic [1:0]        r_state, w_state_nxt;
    logic [LVL_W-1:0]  r_level, w_level_nxt;
    logic [LVL_W-1:0]  r_tgt,   w_tgt_nxt;
    logic [PRE_W-1:0]  r_presc, w_presc_nxt;
    logic [N_LEDS-1:0] r_leds,  w_leds_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;

    logic [LVL_W-1:0]  w_tgt_in;
    logic [LVL_W-1:0]  w_lvl_step;
    logic              w_step;

    assign w_tgt_in = (target > c_max_lvl) ? c_max_lvl : target;
    assign w_step   = (r_presc == c_presc_max);

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_tgt_nxt   = r_tgt;
        w_presc_nxt = r_presc;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_lvl_step  = r_level;

        // Saturating step; the direction invariants already keep level in
        // range, the guards make that independent of them.
        if (r_state == c_st_up) begin
            if (r_level != c_max_lvl) w_lvl_step = r_level + LVL_W'(1);
        end else if (r_state == c_st_down) begin
            if (r_level != '0) w_lvl_step = r_level - LVL_W'(1);
        end

        if (start) begin
            // A start on a step edge wins: direction uses the pre-step level.
            w_tgt_nxt   = w_tgt_in;
            w_presc_nxt = '0;
            if (w_tgt_in > r_level) begin
                w_state_nxt = c_st_up;
                w_busy_nxt  = 1'b1;
            end else if (w_tgt_in < r_level) begin
                w_state_nxt = c_st_down;
                w_busy_nxt  = 1'b1;
            end else begin
                w_state_nxt = c_st_idle;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
        end else if (r_state != c_st_idle) begin
            if (w_step) begin
                w_presc_nxt = '0;
                w_level_nxt = w_lvl_step;
                if (w_lvl_step == r_tgt) begin
`ifdef THERMO_RAMP_AUTO_RETURN_EN
                    if ((r_state == c_st_up) && (r_tgt != '0)) begin
                        w_state_nxt = c_st_down;
                        w_tgt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
`else
                    w_state_nxt = c_st_idle;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
`endif
                end
            end else begin
                w_presc_nxt = r_presc + PRE_W'(1);
            end
        end
    end

    // LEDs are decoded from the next level and registered alongside it so
    // leds and level always change on the same edge.
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_leds
        assign w_leds_nxt[gi] = (w_level_nxt > LVL_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_level <= '0;
            r_tgt   <= '0;
            r_presc <= '0;
            r_leds  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_tgt   <= w_tgt_nxt;
            r_presc <= w_presc_nxt;
            r_leds  <= w_leds_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign leds  = r_leds;
    assign level = r_level;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_thermo_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_thermo_ramp
//  Purpose  : Directed self-checking bench for thermo_ramp with N_LEDS=8,
//             STEP_CYCLES=4. Each scenario task drives start/target and
//             compares {level, leds, busy, done} every cycle against
//             hand-derived expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_thermo_ramp;

    localparam int N_LEDS      = 8;
    localparam int STEP_CYCLES = 4;
    localparam int LVL_W       = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LVL_W-1:0] target;
    logic [N_LEDS-1:0] leds;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    thermo_ramp #(
        .N_LEDS      (N_LEDS),
        .STEP_CYCLES (STEP_CYCLES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .leds   (leds),
        .level  (level),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] therm(input int l);
        logic [8:0] t;
        t = (9'd1 << l) - 9'd1;
        return t[7:0];
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [13:0] exp_v, act_v;
        rst_n  = 1'b0;
        start  = 1'b0;
        target = '0;
        tick;
        tick;
        rst_n = 1'b1;
        act_v = {level, leds, busy, done};
        exp_v = {4'd0, 8'h00, 1'b0, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got {level,leds,busy,done}=%h expected %h", act_v, exp_v);
        end
        // Idle with no start must hold.
        tick;
        act_v = {level, leds, busy, done};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", act_v, exp_v);
        end
    endtask

    // 0 -> 5: steps at edges 4,8,12,16,20, done at 20.
    task automatic test_ramp_up;
        logic [13:0] exp_v, act_v;
        int lvl;
        start = 1'b1; target = 4'd5;
        tick;
        start = 1'b0;
        act_v = {level, leds, busy, done};
        exp_v = {4'd0, 8'h00, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL ramp_up edge 0: got %h expected %h", act_v, exp_v);
        end
        for (int e = 1; e <= 21; e++) begin
            tick;
            lvl   = (e >= 20) ? 5 : e / 4;
            exp_v = {4'(lvl), therm(lvl), (e < 20), (e == 20)};
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL ramp_up edge %0d: got %h expected %h", e, act_v, exp_v);
            end
        end
    endtask

    // 5 -> 2: steps at edges 4,8,12; then same target gives immediate done.
    task automatic test_ramp_down;
        logic [13:0] exp_v, act_v;
        int lvl;
        start = 1'b1; target = 4'd2;
        tick;
        start = 1'b0;
        act_v = {level, leds, busy, done};
        exp_v = {4'd5, 8'h1F, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL ramp_down edge 0: got %h expected %h", act_v, exp_v);
        end
        for (int e = 1; e <= 13; e++) begin
            tick;
            lvl   = (e >= 12) ? 2 : 5 - e / 4;
            exp_v = {4'(lvl), therm(lvl), (e < 12), (e == 12)};
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL ramp_down edge %0d: got %h expected %h", e, act_v, exp_v);
            end
        end
        start = 1'b1; target = 4'd2;
        tick;
        start = 1'b0;
        act_v = {level, leds, busy, done};
        exp_v = {4'd2, 8'h03, 1'b0, 1'b1};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL same_target done: got %h expected %h", act_v, exp_v);
        end
        tick;
        act_v = {level, leds, busy, done};
        exp_v = {4'd2, 8'h03, 1'b0, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL same_target pulse_end: got %h expected %h", act_v, exp_v);
        end
    endtask

    // 0 -> 12 clamps to 8; done at edge 32.
    task automatic test_clamp;
        logic [13:0] exp_v, act_v;
        int lvl;
        do_reset;
        start = 1'b1; target = 4'd12;
        tick;
        start = 1'b0;
        for (int e = 1; e <= 34; e++) begin
            tick;
            lvl   = (e / 4 > 8) ? 8 : e / 4;
            exp_v = {4'(lvl), therm(lvl), (e < 32), (e == 32)};
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL clamp edge %0d: got %h expected %h", e, act_v, exp_v);
            end
        end
    endtask

    // 0 -> 6, retarget to 1 on the edge that would step 3 -> 4.
    task automatic test_retarget;
        logic [13:0] exp_v, act_v;
        int lvl;
        do_reset;
        start = 1'b1; target = 4'd6;
        tick;
        start = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            tick;
            lvl   = e / 4;
            exp_v = {4'(lvl), therm(lvl), 1'b1, 1'b0};
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL retarget pre edge %0d: got %h expected %h", e, act_v, exp_v);
            end
        end
        start = 1'b1; target = 4'd1;
        tick;
        start = 1'b0;
        act_v = {level, leds, busy, done};
        exp_v = {4'd3, 8'h07, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL retarget step_suppressed: got %h expected %h", act_v, exp_v);
        end
        for (int e = 1; e <= 9; e++) begin
            tick;
            lvl   = (e >= 8) ? 1 : 3 - e / 4;
            exp_v = {4'(lvl), therm(lvl), (e < 8), (e == 8)};
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL retarget post edge +%0d: got %h expected %h", e, act_v, exp_v);
            end
        end
    endtask

    // Reset at level 3 mid-ramp: everything clears, start ignored, no done.
    task automatic test_reset_mid;
        logic [13:0] exp_v, act_v;
        do_reset;
        start = 1'b1; target = 4'd6;
        tick;
        start = 1'b0;
        repeat (12) tick;
        act_v = {level, leds, busy, done};
        exp_v = {4'd3, 8'h07, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid pre: got %h expected %h", act_v, exp_v);
        end
        rst_n = 1'b0; start = 1'b1; target = 4'd7;
        tick;
        rst_n = 1'b1; start = 1'b0;
        exp_v = {4'd0, 8'h00, 1'b0, 1'b0};
        for (int e = 0; e <= 8; e++) begin
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid +%0d: got %h expected %h", e, act_v, exp_v);
            end
            tick;
        end
    endtask

`ifdef THERMO_RAMP_AUTO_RETURN_EN
    // 0 -> 3 then automatically back to 0; done only at edge 24.
    task automatic test_auto_return;
        logic [13:0] exp_v, act_v;
        int lvl;
        do_reset;
        start = 1'b1; target = 4'd3;
        tick;
        start = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick;
            if (e <= 12) lvl = e / 4;
            else if (e >= 24) lvl = 0;
            else lvl = 3 - (e - 12) / 4;
            exp_v = {4'(lvl), therm(lvl), (e < 24), (e == 24)};
            act_v = {level, leds, busy, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL auto_return edge %0d: got %h expected %h", e, act_v, exp_v);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        target = '0;
        test_reset;
`ifdef THERMO_RAMP_AUTO_RETURN_EN
        test_auto_return;
        test_reset_mid;
`else
        test_ramp_up;
        test_ramp_down;
        test_clamp;
        test_retarget;
        test_reset_mid;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
